// File: rtl/gol_ctrl_pkg.sv
// Shared types for the Game of Life sequencer.
package gol_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_GO   = 3'd1,
      LOADING   = 3'd2,
      CALC      = 3'd3,
      SWAP_WAIT = 3'd4
   } ctrl_state_t;

endpackage : gol_ctrl_pkg

// File: rtl/gen_tick_timer.sv
// Generation tick timer: counts while enabled and raises a single-deep sticky
// tick request every max(i_period,1) cycles.
module gen_tick_timer #(
   parameter int PERIOD_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_en,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic                i_clr,
   output logic                o_tick_pending
);

   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic [PERIOD_W-1:0] last_cnt;
   logic                pending_q, pending_d;
   logic                wrap;

   // Terminal count is period-1, with a zero period behaving as one.
   // The >= compare keeps the counter sane if the period shrinks mid-count.
   // A fresh tick in the same cycle as a clear wins, so it is not lost.
   always_comb begin
      last_cnt  = (i_period == '0) ? '0 : i_period - PERIOD_W'(1);
      wrap      = (timer_q >= last_cnt);
      timer_d   = '0;
      pending_d = 1'b0;
      if (i_en) begin
         timer_d   = wrap ? '0 : timer_q + PERIOD_W'(1);
         pending_d = wrap | (pending_q & ~i_clr);
      end
   end

   // Timer and pending flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   assign o_tick_pending = pending_q;

endmodule : gen_tick_timer

// File: rtl/gol_sim_controller.sv
// Game of Life top-level sequencer: field loads, generation scheduling and
// frame-synchronous bank swaps.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for load request, single step or free-run tick
// LOAD_GO   | loader start decided; o_load_go pulses on the next cycle
// LOADING   | waiting for the loader busy level to rise and then fall
// CALC      | generation engine running, waiting for i_calc_done
// SWAP_WAIT | back bank complete, waiting for a frame boundary to swap
module gol_sim_controller
   import gol_ctrl_pkg::*;
#(
   parameter int PERIOD_W = 32,
   parameter int GEN_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load_req,
   input  logic                i_step,
   input  logic                i_run,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic                i_loader_busy,
   input  logic                i_calc_done,
   input  logic                i_frame_end,
   output logic                o_load_go,
   output logic                o_calc_start,
   output logic                o_bank_sel,
   output logic [GEN_W-1:0]    o_gen_cnt,
   output logic                o_busy
);

   typedef struct packed {
      ctrl_state_t      state;
      logic             load_go;
      logic             calc_start;
      logic             bank_sel;
      logic             busy;
      logic             load_pending;
      logic             seen_busy;
      logic             reload;
      logic [GEN_W-1:0] gen_cnt;
   } ctrl_regs_t;

   ctrl_regs_t regs_q, regs_d;
   logic       tick_pending;
   logic       tick_clr;

   gen_tick_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_tick_timer (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_en           (i_run),
      .i_period       (i_period),
      .i_clr          (tick_clr),
      .o_tick_pending (tick_pending)
   );

   // Next-state and registered-output decode.
   always_comb begin
      regs_d            = regs_q;
      regs_d.load_go    = 1'b0;
      regs_d.calc_start = 1'b0;
      tick_clr          = 1'b0;

      // Loads requested while busy are remembered and run on return to IDLE.
      if (i_load_req && (regs_q.state != IDLE)) begin
         regs_d.load_pending = 1'b1;
      end

      case (regs_q.state)
         IDLE: begin
            if (i_load_req || regs_q.load_pending) begin
               regs_d.state        = LOAD_GO;
               regs_d.load_pending = 1'b0;
            end else if (i_step || (i_run && tick_pending)) begin
               regs_d.state      = CALC;
               regs_d.calc_start = 1'b1;
               tick_clr          = 1'b1;
            end
         end
         LOAD_GO: begin
            regs_d.load_go   = 1'b1;
            regs_d.seen_busy = 1'b0;
            regs_d.state     = LOADING;
         end
         LOADING: begin
            if (i_loader_busy) begin
               regs_d.seen_busy = 1'b1;
            end
            if (regs_q.seen_busy && !i_loader_busy) begin
               regs_d.state  = SWAP_WAIT;
               regs_d.reload = 1'b1;
            end
         end
         CALC: begin
            if (i_calc_done) begin
               regs_d.state  = SWAP_WAIT;
               regs_d.reload = 1'b0;
            end
         end
         SWAP_WAIT: begin
            if (i_frame_end) begin
               regs_d.bank_sel = ~regs_q.bank_sel;
               regs_d.gen_cnt  = regs_q.reload ? '0 : regs_q.gen_cnt + GEN_W'(1);
               regs_d.state    = IDLE;
            end
         end
         default: begin
            regs_d.state = IDLE;
         end
      endcase

      regs_d.busy = (regs_d.state != IDLE);
   end

   // Single state/output register; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign o_load_go    = regs_q.load_go;
   assign o_calc_start = regs_q.calc_start;
   assign o_bank_sel   = regs_q.bank_sel;
   assign o_gen_cnt    = regs_q.gen_cnt;
   assign o_busy       = regs_q.busy;

endmodule : gol_sim_controller
